// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one active-low column at a time, debounces whole
// scans, and reports each accepted key once plus a 4-digit history of accepted codes.
module keypad_scanner #(
    parameter int CPS       = 1000,
    parameter int DEB_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_n,
    input  logic        clear,
    output logic [3:0]  col_n,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] entry_value
);

    localparam int CW = (CPS > 1) ? $clog2(CPS) : 1;
    localparam int DW = $clog2(DEB_SCANS + 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(CPS - 1);
    localparam logic [DW-1:0] DEB_MAX    = DW'(DEB_SCANS);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    sync1_q, sync1_d, sync2_q, sync2_d;
    logic [CW-1:0] dwell_q, dwell_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [3:0]    col_n_q, col_n_d;
    logic [15:0]   scan_q, scan_d;
    logic          eval_q, eval_d;
    logic [3:0]    cand_q, cand_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [DW-1:0] rel_cnt_q, rel_cnt_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;
    logic [15:0]   entry_q, entry_d;

    // Scan classification: bit index of scan_q is the key code row*4+col
    logic [4:0] hits;
    logic [3:0] hit_code;
    logic       scan_none, scan_single;

    always_comb begin
        hits     = '0;
        hit_code = '0;
        for (int b = 0; b < 16; b++) begin
            hits = hits + 5'(scan_q[b]);
            if (scan_q[b]) hit_code = 4'(b);
        end
        scan_none   = (hits == 5'd0);
        scan_single = (hits == 5'd1);
    end

    logic       sample;
    logic       accept;
    logic [3:0] accept_code;

    always_comb begin
        state_d     = state_q;
        sync1_d     = row_n;
        sync2_d     = sync1_q;
        dwell_d     = dwell_q;
        col_idx_d   = col_idx_q;
        scan_d      = scan_q;
        cand_d      = cand_q;
        deb_cnt_d   = deb_cnt_q;
        rel_cnt_d   = rel_cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        entry_d     = entry_q;
        accept      = 1'b0;
        accept_code = cand_q;

        sample = (dwell_q == DWELL_LAST);
        if (sample) begin
            dwell_d   = '0;
            col_idx_d = col_idx_q + 2'd1;
            for (int r = 0; r < 4; r++) begin
                scan_d[r * 4 + int'(col_idx_q)] = ~sync2_q[r];
            end
        end else begin
            dwell_d = dwell_q + CW'(1);
        end
        // The full scan lands in scan_q on the column-3 sample edge
        eval_d  = sample && (col_idx_q == 2'd3);
        col_n_d = ~(4'b0001 << col_idx_d);

        if (eval_q) begin
            case (state_q)
                IDLE: begin
                    if (scan_single) begin
                        cand_d = hit_code;
                        if (DEB_MAX == DW'(1)) begin
                            accept      = 1'b1;
                            accept_code = hit_code;
                            deb_cnt_d   = '0;
                        end else begin
                            deb_cnt_d = DW'(1);
                            state_d   = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (scan_single && (hit_code == cand_q)) begin
                        if (deb_cnt_q + DW'(1) == DEB_MAX) begin
                            accept    = 1'b1;
                            deb_cnt_d = '0;
                        end else begin
                            deb_cnt_d = deb_cnt_q + DW'(1);
                        end
                    end else begin
                        deb_cnt_d = '0;
                        state_d   = IDLE;
                    end
                end
                PRESSED: begin
                    if (scan_none) begin
                        if (DEB_MAX == DW'(1)) begin
                            key_held_d = 1'b0;
                            rel_cnt_d  = '0;
                            state_d    = IDLE;
                        end else begin
                            rel_cnt_d = DW'(1);
                            state_d   = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (scan_none) begin
                        if (rel_cnt_q + DW'(1) == DEB_MAX) begin
                            key_held_d = 1'b0;
                            rel_cnt_d  = '0;
                            state_d    = IDLE;
                        end else begin
                            rel_cnt_d = rel_cnt_q + DW'(1);
                        end
                    end else begin
                        rel_cnt_d = '0;
                        state_d   = PRESSED;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (accept) begin
            state_d     = PRESSED;
            key_code_d  = accept_code;
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            entry_d     = {entry_q[11:0], accept_code};
        end
        // Clear overrides the history shift but leaves the key report intact
        if (clear) entry_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sync1_q     <= 4'b1111;
            sync2_q     <= 4'b1111;
            dwell_q     <= '0;
            col_idx_q   <= 2'd0;
            col_n_q     <= 4'b1110;
            scan_q      <= '0;
            eval_q      <= 1'b0;
            cand_q      <= '0;
            deb_cnt_q   <= '0;
            rel_cnt_q   <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            entry_q     <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            dwell_q     <= dwell_d;
            col_idx_q   <= col_idx_d;
            col_n_q     <= col_n_d;
            scan_q      <= scan_d;
            eval_q      <= eval_d;
            cand_q      <= cand_d;
            deb_cnt_q   <= deb_cnt_d;
            rel_cnt_q   <= rel_cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            entry_q     <= entry_d;
        end
    end

    assign col_n       = col_n_q;
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_held    = key_held_q;
    assign entry_value = entry_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives rows from the column drive;
// a scan-level streak model predicts accepted keys, their timing and the entry history.
module tb_keypad_scanner;

    localparam int CPS = 4;
    localparam int DEB = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row_n;
    logic        clear;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] entry_value;

    keypad_scanner #(.CPS(CPS), .DEB_SCANS(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .row_n(row_n), .clear(clear), .col_n(col_n),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
        .entry_value(entry_value)
    );

    always #5 clk = ~clk;

    logic [15:0] keys;
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_n[r] = 1'b1;
            for (int c = 0; c < 4; c++)
                if (!col_n[c] && keys[r * 4 + c]) row_n[r] = 1'b0;
        end
    end

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    longint c0 = 0;
    bit     run_on = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [3:0]  code;
        longint      at;
        logic [15:0] entry;
    } pulse_t;
    pulse_t exp_q[$];

    // Scan-level reference: a key is accepted after DEB matching single-key scans in a
    // row while nothing is held, and released after DEB key-free scans in a row.
    int          m_streak, m_none;
    logic [3:0]  m_cand, m_kcode;
    bit          m_held;
    logic [15:0] m_entry;

    task automatic model_reset();
        m_streak = 0; m_none = 0; m_cand = 0; m_kcode = 0; m_held = 0; m_entry = 0;
    endtask

    task automatic model_scan(input logic [15:0] k, input bit clr, input longint start);
        int n;
        logic [3:0] code;
        pulse_t p;
        n = $countones(k);
        code = 0;
        for (int b = 0; b < 16; b++) if (k[b]) code = 4'(b);
        if (!m_held) begin
            if (n == 1 && m_streak > 0 && code == m_cand) m_streak++;
            else if (n == 1 && m_streak == 0) begin m_streak = 1; m_cand = code; end
            else m_streak = 0;
            if (m_streak == DEB) begin
                m_held = 1; m_streak = 0; m_none = 0; m_kcode = m_cand;
                m_entry = clr ? 16'h0 : {m_entry[11:0], m_cand};
                p.code = m_cand; p.at = start + 4 * CPS + 1; p.entry = m_entry;
                exp_q.push_back(p);
            end
        end else begin
            if (n == 0) begin
                m_none++;
                if (m_none == DEB) begin m_held = 0; m_none = 0; end
            end else m_none = 0;
        end
        if (clr) m_entry = 16'h0;
    endtask

    always @(negedge clk) begin
        if (run_on) begin
            int ph;
            logic [3:0] ec;
            ph = int'(((cyc - c0) / CPS) % 4);
            ec = ~(4'b0001 << ph);
            chk("col_n", col_n, ec);
        end
        if (key_valid) begin
            if (exp_q.size() == 0) chk("unexpected_key_valid", 1, 0);
            else begin
                pulse_t p;
                p = exp_q.pop_front();
                chk("pulse_code", key_code, p.code);
                chk("pulse_cycle", cyc, p.at);
                chk("pulse_entry", entry_value, p.entry);
            end
        end
    end

    bit          pend = 0;
    bit          p_held;
    logic [3:0]  p_code;
    logic [15:0] p_entry;

    // One aligned scan: entered and left at #1 into the column-0, dwell-0 cycle
    task automatic do_scan(input logic [15:0] k, input bit clr, input bit use_tbl,
                           input bit t_held, input logic [3:0] t_code, input logic [15:0] t_entry);
        keys = k;
        model_scan(k, clr, cyc);
        @(posedge clk); #1;
        clear = 1'b0;
        if (pend) begin
            chk("key_held", key_held, p_held);
            chk("key_code", key_code, p_code);
            chk("entry_value", entry_value, p_entry);
        end
        pend    = 1;
        p_held  = use_tbl ? t_held  : m_held;
        p_code  = use_tbl ? t_code  : m_kcode;
        p_entry = use_tbl ? t_entry : m_entry;
        repeat (4 * CPS - 2) @(posedge clk);
        #1;
        if (clr) clear = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_col_n", col_n, 4'b1110);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_key_held", key_held, 0);
        chk("rst_key_code", key_code, 0);
        chk("rst_entry", entry_value, 0);
    endtask

    typedef struct {
        logic [15:0] k;
        bit          held;
        logic [3:0]  code;
        logic [15:0] entry;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [15:0] k, input bit h, input logic [3:0] c, input logic [15:0] e);
        vec_t v;
        v.k = k; v.held = h; v.code = c; v.entry = e;
        tbl.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; keys = '0; clear = 1'b0;
        model_reset();
        // idle, single key 9 (row 2, col 1), release
        add(16'h0000, 0, 4'h0, 16'h0000); add(16'h0000, 0, 4'h0, 16'h0000);
        add(16'h0200, 0, 4'h0, 16'h0000); add(16'h0200, 1, 4'h9, 16'h0009);
        add(16'h0200, 1, 4'h9, 16'h0009); add(16'h0000, 1, 4'h9, 16'h0009);
        add(16'h0000, 0, 4'h9, 16'h0009);
        // keys 1,2,3,4 then A with full releases
        add(16'h0002, 0, 4'h9, 16'h0009); add(16'h0002, 1, 4'h1, 16'h0091);
        add(16'h0000, 1, 4'h1, 16'h0091); add(16'h0000, 0, 4'h1, 16'h0091);
        add(16'h0004, 0, 4'h1, 16'h0091); add(16'h0004, 1, 4'h2, 16'h0912);
        add(16'h0000, 1, 4'h2, 16'h0912); add(16'h0000, 0, 4'h2, 16'h0912);
        add(16'h0008, 0, 4'h2, 16'h0912); add(16'h0008, 1, 4'h3, 16'h9123);
        add(16'h0000, 1, 4'h3, 16'h9123); add(16'h0000, 0, 4'h3, 16'h9123);
        add(16'h0010, 0, 4'h3, 16'h9123); add(16'h0010, 1, 4'h4, 16'h1234);
        add(16'h0000, 1, 4'h4, 16'h1234); add(16'h0000, 0, 4'h4, 16'h1234);
        add(16'h0400, 0, 4'h4, 16'h1234); add(16'h0400, 1, 4'hA, 16'h234A);
        add(16'h0000, 1, 4'hA, 16'h234A); add(16'h0000, 0, 4'hA, 16'h234A);
        // bounce on key B
        add(16'h0800, 0, 4'hA, 16'h234A); add(16'h0000, 0, 4'hA, 16'h234A);
        add(16'h0800, 0, 4'hA, 16'h234A); add(16'h0800, 1, 4'hB, 16'h34AB);
        add(16'h0000, 1, 4'hB, 16'h34AB); add(16'h0000, 0, 4'hB, 16'h34AB);
        // multi from idle, second key while held, interrupted release
        add(16'h0060, 0, 4'hB, 16'h34AB); add(16'h0060, 0, 4'hB, 16'h34AB);
        add(16'h0020, 0, 4'hB, 16'h34AB); add(16'h0020, 1, 4'h5, 16'h4AB5);
        add(16'h0060, 1, 4'h5, 16'h4AB5); add(16'h0060, 1, 4'h5, 16'h4AB5);
        add(16'h0000, 1, 4'h5, 16'h4AB5); add(16'h0020, 1, 4'h5, 16'h4AB5);
        add(16'h0000, 1, 4'h5, 16'h4AB5); add(16'h0000, 0, 4'h5, 16'h4AB5);

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1; c0 = cyc; run_on = 1;

        foreach (tbl[i]) do_scan(tbl[i].k, 0, 1, tbl[i].held, tbl[i].code, tbl[i].entry);

        // clear coinciding with the accept of key 7
        do_scan(16'h0080, 0, 1, 0, 4'h5, 16'h4AB5);
        do_scan(16'h0080, 1, 1, 1, 4'h7, 16'h0000);
        do_scan(16'h0000, 0, 1, 1, 4'h7, 16'h0000);
        do_scan(16'h0000, 0, 1, 0, 4'h7, 16'h0000);
        do_scan(16'h0001, 0, 1, 0, 4'h7, 16'h0000);

        // reset in the middle of the second debounce scan
        keys = 16'h0001;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0; run_on = 0;
        @(posedge clk); #1;
        check_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1; c0 = cyc; run_on = 1;
        pend = 0;
        model_reset();
        do_scan(16'h0001, 0, 1, 0, 4'h0, 16'h0000);
        do_scan(16'h0000, 0, 1, 0, 4'h0, 16'h0000);

        for (int i = 0; i < 60; i++) begin
            logic [15:0] k;
            int kind, reps, a, b;
            kind = $urandom_range(0, 9);
            a = $urandom_range(0, 15);
            b = (a + $urandom_range(1, 15)) % 16;
            k = '0;
            if (kind >= 5) k[a] = 1'b1;
            if (kind >= 8) k[b] = 1'b1;
            reps = $urandom_range(1, 3);
            for (int j = 0; j < reps; j++) do_scan(k, 0, 0, 0, 4'h0, 16'h0);
        end
        do_scan(16'h0000, 0, 0, 0, 4'h0, 16'h0);
        do_scan(16'h0000, 0, 0, 0, 4'h0, 16'h0);
        do_scan(16'h0000, 0, 0, 0, 4'h0, 16'h0);

        chk("pulses_outstanding", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter CPS, default 1000: clock cycles each column is driven before its rows are sampled.
REQ-002 SHALL have parameter DEB_SCANS, default 4: consecutive matching full scans required for press and for release.
REQ-003 SHALL have port clk  input  1  system clock; the only clock.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port row_n  input  4  keypad rows, active-low (pulled up externally), asynchronous to clk.
REQ-006 SHALL have port clear  input  1  synchronous clear of entry_value.
REQ-007 SHALL have port col_n  output  4  column drive, active-low, exactly one bit low at all times.
REQ-008 SHALL have port key_code  output  4  code of last accepted key, row*4 + col.
REQ-009 SHALL have port key_valid  output  1  one-cycle pulse on each accepted press.
REQ-010 SHALL have port key_held  output  1  high while the accepted key is held.
REQ-011 SHALL have port entry_value  output  16  last four accepted codes, newest in [3:0]; intended to drive the 4-digit display.

Function
REQ-012 SHALL pass row_n through a two-flop synchronizer before any use.
REQ-013 SHALL drive col_n = ~(4'b0001 << col_idx) with col_idx in 0..3.
REQ-014 SHALL count a dwell counter 0..CPS-1; at CPS-1 it SHALL sample the synchronized rows for col_idx, reset the counter, and advance col_idx (3 wraps to 0).
REQ-015 SHALL define one full scan as 4*CPS cycles; the scan result SHALL be evaluated in the cycle after the column-3 sample.
REQ-016 SHALL classify each scan result as NONE (no active row bits), SINGLE (exactly one of 16 bits active, with code), or MULTI (two or more active).
REQ-017 SHALL implement FSM states IDLE, DEBOUNCE, PRESSED, RELEASE.
REQ-018 In IDLE: on SINGLE, latch candidate code, set deb_cnt=1 and go to DEBOUNCE; on NONE or MULTI, stay.
REQ-019 In DEBOUNCE: on SINGLE with the same code, increment deb_cnt; otherwise return to IDLE and clear deb_cnt.
REQ-020 When deb_cnt reaches DEB_SCANS, SHALL go to PRESSED, load key_code with the candidate, pulse key_valid for exactly one cycle, and shift entry_value <= {entry_value[11:0], candidate}.
REQ-021 In PRESSED: key_held=1; on NONE, set rel_cnt=1 and go to RELEASE; on SINGLE or MULTI, stay.
REQ-022 In RELEASE: key_held=1; on NONE, increment rel_cnt and go to IDLE (key_held=0) when it reaches DEB_SCANS; on any key, return to PRESSED with rel_cnt=0.
REQ-023 SHALL accept no new key until release completes; a second key pressed while one is held SHALL be ignored.
REQ-024 When DEB_SCANS=1, a single SINGLE scan SHALL accept the key and a single NONE scan SHALL release it.
REQ-025 clear SHALL set entry_value to 0 on the next edge; if clear and an accept coincide, clear SHALL win for entry_value, while key_valid and key_code SHALL still update.
REQ-026 key_valid SHALL rise exactly one cycle after the evaluation cycle of the accepting scan.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 While rst_n=0 at a clk edge, SHALL set: state IDLE, col_idx 0, col_n 4'b1110, dwell counter 0, deb_cnt and rel_cnt 0, synchronizer flops 4'b1111, key_code 0, key_valid 0, key_held 0, entry_value 0.
REQ-029 Reset asserted mid-scan or mid-debounce SHALL abandon all progress; scanning SHALL restart at column 0 with dwell count 0 on the first cycle after rst_n returns high.

Verification (CPS=4, DEB_SCANS=2; scan = 16 cycles)
REQ-030 Idle, no keys: col_n steps 1110, 1101, 1011, 0111 every 4 cycles and wraps; key_valid never asserts.
REQ-031 Hold key at row 2, col 1: exactly one key_valid pulse, key_code=9, entry_value=0x0009, key_held high; release for 2 scans drops key_held.
REQ-032 Press the sequence 1, 2, 3, 4 with full releases between: entry_value=0x1234; a fifth press of 0xA gives 0x234A.
REQ-033 Key bounces (present for 1 scan, absent for 1, present again): no key_valid until 2 consecutive matching scans.
REQ-034 Two keys pressed together (MULTI) from IDLE: no key_valid. Second key added while the first is held: no second pulse.
REQ-035 Assert clear in the same cycle as key_valid: entry_value=0, key_code updated. Assert rst_n=0 mid-debounce: all outputs reset and col_n=1110.
